// File: rtl/add_pkg.sv
// add_pkg: width helpers shared by the adder tree and its stages.
package add_pkg;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int tree_w(input int iw, input int n);
        return iw + clog2(n);
    endfunction
    function automatic int acc_w(input int tw, input int acc_len);
        return tw + clog2(acc_len);
    endfunction
endpackage

// File: rtl/add_stage.sv
// add_stage: one registered level of the adder tree, P pairwise sums with a travelling valid bit.
module add_stage #(
    parameter int P = 2,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [2*P*W-1:0]     din,
    output logic                 out_valid,
    output logic [P*(W+1)-1:0]   dout
);
    logic [P*(W+1)-1:0] sum;
    for (genvar i = 0; i < P; i++) begin : g_pair
        assign sum[i*(W+1) +: W+1] = {din[2*i*W+W-1], din[2*i*W +: W]}
                                   + {din[(2*i+2)*W-1], din[(2*i+1)*W +: W]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) dout <= sum;
        end
    end
endmodule

// File: rtl/add_tree_acc.sv
// add_tree_acc: pipelined signed adder tree over N channels with optional integrate-and-dump.
module add_tree_acc
    import add_pkg::*;
#(
    parameter int N       = 4,
    parameter int IW      = 16,
    parameter int ACC_LEN = 1,
    localparam int L      = clog2(N),
    localparam int TW     = tree_w(IW, N),
    localparam int OW     = acc_w(TW, ACC_LEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [N*IW-1:0] din,
    output logic            out_valid,
    output logic [OW-1:0]   dout
);
    localparam int CW = ACC_LEN > 1 ? clog2(ACC_LEN) : 1;

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("add_tree_acc: N must be a power of two and at least 2");
    end
    if (ACC_LEN < 1) begin : g_bad_acc
        $error("add_tree_acc: ACC_LEN must be at least 1");
    end

    for (genvar s = 1; s <= L; s++) begin : g_stage
        localparam int P = N >> s;
        localparam int W = IW + s - 1;
        logic [2*P*W-1:0]   a;
        logic               va;
        logic [P*(W+1)-1:0] q;
        logic               v;
        if (s == 1) begin : g_first
            assign a  = din;
            assign va = in_valid;
        end else begin : g_next
            assign a  = g_stage[s-1].q;
            assign va = g_stage[s-1].v;
        end
        add_stage #(.P(P), .W(W)) u_stage (
            .clk(clk), .rst_n(rst_n), .clear(clear),
            .in_valid(va), .din(a), .out_valid(v), .dout(q)
        );
    end

    logic [TW-1:0]        tree_q;
    logic                 tree_v;
    logic [CW-1:0]        cnt;
    logic signed [OW-1:0] acc, ext, sum;
    logic                 last;

    assign tree_q = g_stage[L].q;
    assign tree_v = g_stage[L].v;
    assign ext    = OW'($signed(tree_q));
    assign sum    = (cnt == '0 ? '0 : acc) + ext;
    assign last   = cnt == CW'(ACC_LEN - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            acc       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= tree_v && last;
            if (tree_v && last) begin
                dout <= sum;
                cnt  <= '0;
            end else if (tree_v) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_add_tree_acc.sv
// tb_add_tree_acc: table vectors, hand-written clear/reset sequences and a randomized model check.
module tb_add_tree_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v_a = 0, v_b = 0, v_c = 0, clr_b = 0;
    logic [63:0] din_a = '0, din_b = '0, din_c = '0;
    logic        ov_a, ov_b, ov_c;
    logic [17:0] dout_a;
    logic [19:0] dout_b;
    logic [10:0] dout_c;

    add_tree_acc #(.N(4), .IW(16), .ACC_LEN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(v_a), .din(din_a),
        .out_valid(ov_a), .dout(dout_a));
    add_tree_acc #(.N(4), .IW(16), .ACC_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clr_b), .in_valid(v_b), .din(din_b),
        .out_valid(ov_b), .dout(dout_b));
    add_tree_acc #(.N(8), .IW(8), .ACC_LEN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(v_c), .din(din_c),
        .out_valid(ov_c), .dout(dout_c));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    int pulses_b;
    int last_b;
    logic seen_b;

    // Drives one cycle on dut_b and records what the output showed after that edge.
    task automatic step_b(input logic v, input int a, input int b, input int c, input int d,
                          input logic clr);
        v_b   = v;
        din_b = v ? pack4(a, b, c, d) : '0;
        clr_b = clr;
        @(negedge clk);
        seen_b = ov_b;
        if (ov_b) begin
            pulses_b++;
            last_b = int'($signed(dout_b));
        end
    endtask

    typedef struct {
        logic v;
        int   c0, c1, c2, c3;
        int   exp;
    } vec_t;
    localparam int NV = 10;
    vec_t tbl[NV];

    typedef struct {
        int due;
        int val;
    } pend_t;
    pend_t q[$];

    int   j, held, s;
    logic ev, rv;
    logic [63:0] rd;

    initial begin
        tbl[0] = '{1'b1, 1, 2, 3, 4, 10};
        tbl[1] = '{1'b0, 0, 0, 0, 0, 0};
        tbl[2] = '{1'b0, 0, 0, 0, 0, 0};
        tbl[3] = '{1'b0, 0, 0, 0, 0, 0};
        tbl[4] = '{1'b1, -32768, -32768, -32768, -32768, -131072};
        tbl[5] = '{1'b1, 32767, 32767, 32767, 32767, 131068};
        tbl[6] = '{1'b1, -1, 1, -1, 1, 0};
        tbl[7] = '{1'b0, 0, 0, 0, 0, 0};
        tbl[8] = '{1'b1, 32767, -32768, 0, 5, 4};
        tbl[9] = '{1'b1, -100, -200, 300, -7, -7};

        repeat (3) @(negedge clk);
        chk("reset_ov_a", int'(ov_a), 0);
        chk("reset_dout_a", int'($signed(dout_a)), 0);
        chk("reset_ov_b", int'(ov_b), 0);
        chk("reset_dout_b", int'($signed(dout_b)), 0);
        rst_n = 1'b1;

        // Pass-through vectors, back to back, latency L+1 = 3
        held = 0;
        for (int i = 0; i < NV + 3; i++) begin
            j  = i - 3;
            ev = 1'b0;
            if (j >= 0 && tbl[j].v) begin
                ev   = 1'b1;
                held = tbl[j].exp;
            end
            chk($sformatf("vec%0d_valid", j), int'(ov_a), int'(ev));
            chk($sformatf("vec%0d_dout", j), int'($signed(dout_a)), held);
            if (i < NV) begin
                v_a   = tbl[i].v;
                din_a = pack4(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3);
            end else begin
                v_a   = 1'b0;
                din_a = '0;
            end
            @(negedge clk);
        end

        // Four samples with random gaps produce a single pulse
        pulses_b = 0;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) step_b(0, 0, 0, 0, 0, 0);
            step_b(1, 1, 2, 3, 4, 0);
        end
        chk("acc_no_early_pulse", pulses_b, 0);
        for (int k = 1; k <= 3; k++) begin
            step_b(0, 0, 0, 0, 0, 0);
            chk($sformatf("acc_pulse_at_%0d", k), int'(seen_b), int'(k == 2));
        end
        chk("acc_pulse_count", pulses_b, 1);
        chk("acc_dout", int'($signed(dout_b)), 40);

        // Clear with a simultaneous sample drops partials and the sample
        pulses_b = 0;
        step_b(1, 1, 2, 3, 4, 0);
        step_b(1, 1, 2, 3, 4, 0);
        step_b(1, 9, 9, 9, 9, 1);
        chk("clear_dout", int'($signed(dout_b)), 0);
        chk("clear_ov", int'(ov_b), 0);
        repeat (4) step_b(1, -1, -1, -1, -2, 0);
        repeat (4) step_b(0, 0, 0, 0, 0, 0);
        chk("clear_pulse_count", pulses_b, 1);
        chk("clear_result", last_b, -20);

        // Asynchronous reset mid-group, between edges
        pulses_b = 0;
        step_b(1, 1, 2, 3, 4, 0);
        step_b(1, 1, 2, 3, 4, 0);
        repeat (3) step_b(0, 0, 0, 0, 0, 0);
        chk("pre_reset_dout", int'($signed(dout_b)), -20);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_dout", int'($signed(dout_b)), 0);
        chk("async_reset_ov", int'(ov_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step_b(1, 1, 2, 2, 2, 0);
        repeat (4) step_b(0, 0, 0, 0, 0, 0);
        chk("post_reset_pulse_count", pulses_b, 1);
        chk("post_reset_result", last_b, 28);

        // Random stream on N=8, IW=8: every accepted sample appears 4 cycles later
        held = 0;
        for (int i = 0; i < 10005; i++) begin
            ev = q.size() > 0 && q[0].due == i;
            chk("rnd_valid", int'(ov_c), int'(ev));
            if (ev) begin
                held = q[0].val;
                void'(q.pop_front());
            end
            chk("rnd_dout", int'($signed(dout_c)), held);
            rv = i < 10000 && $urandom_range(0, 3) != 0;
            rd = {$urandom, $urandom};
            if (rv) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += int'($signed(rd[k*8 +: 8]));
                q.push_back('{i + 4, s});
            end
            v_c   = rv;
            din_c = rd;
            @(negedge clk);
        end
        chk("rnd_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
